// File: rtl/lottery_input_conditioner_pkg.sv
// Shared constants and types for the lottery input-conditioning stage.
package lottery_pkg;

  // Bit positions within key_n
  localparam int KEY_INSERT = 0;
  localparam int KEY_FINISH = 1;
  localparam int NUM_KEYS   = 2;

  // Largest digit the downstream FSM accepts
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  // Debounce channel states
  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_e;

endpackage

// File: rtl/lottery_input_conditioner_key_debounce.sv
// One push-button channel: 2-FF synchronizer, inversion to active-high,
// and a press/release debounce FSM that flags an accepted press.
module key_debounce
  import lottery_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic press_strobe_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          pressed;
  deb_state_e    state_q;
  logic [CW-1:0] cnt_q;

  // Two-stage synchronizer; reset to the released level so a held key looks released
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  // The strobe is the decoded PRESS_WAIT->HELD transition. It is built only
  // from flops, so it is glitch-free, and the top registers it at the same
  // edge the FSM enters HELD, which keeps press latency at DEBOUNCE_CYCLES+1.
  assign press_strobe_o = (state_q == PRESS_WAIT) && pressed && (cnt_q == CNT_LAST);

  // Debounce FSM; reset lands in RELEASE_WAIT so a full release must be seen first
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RELEASE_WAIT;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pressed) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!pressed) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HELD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (!pressed) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (pressed) begin
            state_q <= HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= RELEASE_WAIT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lottery_input_conditioner.sv
// Input conditioner for the lottery FSM: debounced insert/finish pulses,
// synchronized and range-checked digit, finish deferred when it collides
// with insert.
module lottery_input_conditioner
  import lottery_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] key_n,
  input  logic [3:0] sw,
  output logic [3:0] num,
  output logic       insert,
  output logic       finish,
  output logic       digit_err
);

  logic [3:0]          sw_sync1_q;
  logic [3:0]          sw_sync2_q;
  logic [NUM_KEYS-1:0] strobe;
  logic [3:0]          num_q;
  logic                insert_q;
  logic                finish_q;
  logic                digit_err_q;
  logic                finish_pending_q;

  // One debounce channel per push-button
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key_debounce (
        .clk           (clk),
        .reset         (reset),
        .key_n_i       (key_n[gi]),
        .press_strobe_o(strobe[gi])
      );
    end
  endgenerate

  // Two-stage synchronizer for the digit switches
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= sw;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  // Pulse generation: range check on insert, finish deferred one cycle on collision
  always_ff @(posedge clk) begin
    if (reset) begin
      num_q            <= '0;
      insert_q         <= 1'b0;
      finish_q         <= 1'b0;
      digit_err_q      <= 1'b0;
      finish_pending_q <= 1'b0;
    end else begin
      insert_q         <= 1'b0;
      finish_q         <= 1'b0;
      digit_err_q      <= 1'b0;
      finish_pending_q <= 1'b0;
      if (finish_pending_q) begin
        finish_q <= 1'b1;
      end
      if (strobe[KEY_INSERT]) begin
        if (sw_sync2_q <= MAX_DIGIT) begin
          insert_q <= 1'b1;
          num_q    <= sw_sync2_q;
        end else begin
          digit_err_q <= 1'b1;
        end
      end
      if (strobe[KEY_FINISH]) begin
        if (strobe[KEY_INSERT]) begin
          finish_pending_q <= 1'b1;
        end else begin
          finish_q <= 1'b1;
        end
      end
    end
  end

  assign num       = num_q;
  assign insert    = insert_q;
  assign finish    = finish_q;
  assign digit_err = digit_err_q;

endmodule

// File: tb/tb_lottery_input_conditioner.sv
// Bench for lottery_input_conditioner: directed scenarios plus random key/switch
// activity, checked by a scoreboard fed from a run-length debounce model.
module tb_lottery_input_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] key_n = 2'b11;
  logic [3:0] sw = 4'd0;
  logic [3:0] num;
  logic       insert;
  logic       finish;
  logic       digit_err;

  lottery_input_conditioner #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_n    (key_n),
    .sw       (sw),
    .num      (num),
    .insert   (insert),
    .finish   (finish),
    .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  // kind: 0 = insert, 1 = finish, 2 = digit_err
  typedef struct {
    int         kind;
    logic [3:0] num;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int ins_cnt = 0;
  int fin_cnt = 0;
  int err_cnt = 0;
  int last_ins_cyc = -1;
  int last_fin_cyc = -1;

  // ---------------- reference model ----------------
  // A press is accepted when the synchronized pressed level has been seen on
  // D consecutive samples while the key is "armed"; a key becomes armed after
  // D consecutive released samples. Reset disarms and clears run lengths.
  logic [1:0] m_k1, m_k2;
  logic [3:0] m_w1, m_w2;
  int         run_len [2];
  bit         last_lvl[2];
  bit         armed   [2];
  bit         stb     [2];
  bit         m_pend;
  logic [3:0] m_num;
  logic [3:0] m_wsync;
  bit         lvl;

  function automatic ev_t mk(int kind, logic [3:0] n, int c);
    ev_t e;
    e.kind = kind;
    e.num  = n;
    e.cyc  = c;
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_k1   = 2'b11;
      m_k2   = 2'b11;
      m_w1   = 4'd0;
      m_w2   = 4'd0;
      m_pend = 1'b0;
      m_num  = 4'd0;
      for (int c = 0; c < 2; c++) begin
        run_len[c]  = 0;
        last_lvl[c] = 1'b0;
        armed[c]    = 1'b0;
      end
    end else begin
      m_wsync = m_w2;
      for (int c = 0; c < 2; c++) begin
        lvl = ~m_k2[c];
        if (lvl == last_lvl[c]) begin
          if (run_len[c] < 1000) run_len[c]++;
        end else begin
          run_len[c] = 1;
        end
        last_lvl[c] = lvl;
        stb[c] = 1'b0;
        if (lvl && armed[c] && run_len[c] == D) begin
          stb[c]   = 1'b1;
          armed[c] = 1'b0;
        end else if (!lvl && run_len[c] >= D) begin
          armed[c] = 1'b1;
        end
      end
      if (m_pend) begin
        exp_q.push_back(mk(1, m_num, cyc));
        m_pend = 1'b0;
      end
      if (stb[0]) begin
        if (m_wsync <= 4'd9) begin
          m_num = m_wsync;
          exp_q.push_back(mk(0, m_num, cyc));
        end else begin
          exp_q.push_back(mk(2, m_num, cyc));
        end
      end
      if (stb[1]) begin
        if (stb[0]) m_pend = 1'b1;
        else exp_q.push_back(mk(1, m_num, cyc));
      end
      m_k2 = m_k1;
      m_k1 = key_n;
      m_w2 = m_w1;
      m_w1 = sw;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int  got_kind;
  ev_t e;

  always @(negedge clk) begin
    if (cyc > 0) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        $display("FAIL missed_pulse: kind %0d expected at cycle %0d, no pulse observed (now cycle %0d)",
                 e.kind, e.cyc, cyc);
      end
      if (insert || finish || digit_err) begin
        checks++;
        if ($countones({insert, finish, digit_err}) == 1) passed++;
        else $display("FAIL onehot: cycle %0d ins=%0b fin=%0b err=%0b, required at most one high",
                      cyc, insert, finish, digit_err);
        got_kind = insert ? 0 : (finish ? 1 : 2);
        if (insert) begin ins_cnt++; last_ins_cyc = cyc; end
        if (finish) begin fin_cnt++; last_fin_cyc = cyc; end
        if (digit_err) err_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_pulse: cycle %0d kind %0d num %0d, required no pulse",
                   cyc, got_kind, num);
        end else begin
          e = exp_q.pop_front();
          if (e.kind == got_kind && e.cyc == cyc && e.num == num) passed++;
          else $display("FAIL pulse: got kind %0d num %0d cycle %0d, required kind %0d num %0d cycle %0d",
                        got_kind, num, cyc, e.kind, e.num, e.cyc);
        end
      end
      checks++;
      if (num == m_num) passed++;
      else $display("FAIL num_track: cycle %0d num %0d, required %0d", cyc, num, m_num);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual == required) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, actual, required);
  endtask

  task automatic press(input int k, input int hold, input int gap);
    key_n[k] = 1'b0;
    tick(hold);
    key_n[k] = 1'b1;
    tick(gap);
  endtask

  int t0;
  int fin_before;
  int ins_before;
  int hold;

  initial begin
    // Reset state
    tick(3);
    #1;
    check("reset_num", int'(num), 0);
    check("reset_insert", int'(insert), 0);
    check("reset_finish", int'(finish), 0);
    check("reset_digit_err", int'(digit_err), 0);
    @(negedge clk);
    reset = 1'b0;
    tick(8);

    // Clean press, sw=5
    sw = 4'd5;
    tick(4);
    key_n[0] = 1'b0;
    t0 = cyc + 1;
    tick(20);
    key_n[0] = 1'b1;
    tick(12);
    #1;
    check("clean_insert_count", ins_cnt, 1);
    check("clean_latency_cycle", last_ins_cyc, t0 + 5);
    check("clean_num", int'(num), 5);

    // Bounce: 2 low / 2 high, three times
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      key_n[0] = ~key_n[0];
      tick(2);
    end
    key_n[0] = 1'b1;
    tick(12);
    #1;
    check("bounce_insert_count", ins_cnt, 1);
    check("bounce_num", int'(num), 5);

    // Range check: sw = 0xB
    @(negedge clk);
    sw = 4'hB;
    tick(4);
    press(0, 20, 12);
    #1;
    check("range_err_count", err_cnt, 1);
    check("range_insert_count", ins_cnt, 1);
    check("range_num", int'(num), 5);

    // Simultaneous insert + finish, sw=7
    @(negedge clk);
    sw = 4'd7;
    tick(4);
    key_n = 2'b00;
    t0 = cyc + 1;
    tick(20);
    key_n = 2'b11;
    tick(12);
    #1;
    check("simul_insert_count", ins_cnt, 2);
    check("simul_insert_cycle", last_ins_cyc, t0 + 5);
    check("simul_num", int'(num), 7);
    check("simul_finish_count", fin_cnt, 1);
    check("simul_finish_next_cycle", last_fin_cyc, last_ins_cyc + 1);

    // Reset with finish button held
    @(negedge clk);
    key_n[1] = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    #1;
    check("rst_held_num", int'(num), 0);
    check("rst_held_outputs", int'({insert, finish, digit_err}), 0);
    fin_before = fin_cnt;
    @(negedge clk);
    tick(20);
    #1;
    check("rst_held_no_finish", fin_cnt, fin_before);
    @(negedge clk);
    key_n[1] = 1'b1;
    tick(8);
    press(1, 10, 10);
    #1;
    check("rst_held_repress_finish", fin_cnt, fin_before + 1);

    // Reset in the middle of an insert debounce
    @(negedge clk);
    sw = 4'd3;
    tick(4);
    ins_before = ins_cnt;
    key_n[0] = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(20);
    key_n[0] = 1'b1;
    tick(12);
    #1;
    check("middeb_no_insert", ins_cnt, ins_before);
    check("middeb_num", int'(num), 0);

    // Random activity
    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      key_n = 2'($urandom);
      sw    = 4'($urandom_range(0, 15));
      hold  = $urandom_range(1, 14);
      if ($urandom_range(0, 40) == 0) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      tick(hold);
    end
    key_n = 2'b11;
    tick(20);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
